// File: rtl/wide_add_pkg.sv
// Shared types and elaboration helpers for the sliced wide adder.
// No logic of its own; no latency or backpressure.
// Imported by the sequencer top.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // Slice index width, never narrower than one bit.
    function automatic int calc_idx_w(input int nslice);
        return (nslice <= 2) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/add_slice.sv
// SLICE-bit adder with carry in and carry out.
// Purely combinational, zero latency.
// No handshake; the caller sequences it.
module add_slice #(
    parameter int SLICE = 32
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/wide_add_seq.sv
// WIDTH-bit add/subtract reusing one SLICE-bit adder, least-significant slice first.
// Latency: accept on edge E, out_valid after edge E+NSLICE; NSLICE+2 cycles per op.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int WIDTH = 512,
    parameter int SLICE = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int IDXW   = calc_idx_w(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    generate
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
            $fatal(1, "wide_add_seq: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  res_q;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;

    int                base;
    logic [SLICE-1:0]  a_k;
    logic [SLICE-1:0]  b_k;
    logic [SLICE-1:0]  sum_k;
    logic              cout_k;

    assign base = int'(idx_q) * SLICE;
    assign a_k  = a_q[base +: SLICE];
    assign b_k  = b_q[base +: SLICE];

    add_slice #(
        .SLICE (SLICE)
    ) u_add_slice (
        .a    (a_k),
        .b    (b_k),
        .cin  (carry_q),
        .sum  (sum_k),
        .cout (cout_k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + 1: invert b here, seed the carry with 1.
                        a_q     <= a;
                        b_q     <= op_sub ? ~b : b;
                        carry_q <= op_sub | cin;
                        idx_q   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res_q[base +: SLICE] <= sum_k;
                    carry_q              <= cout_k;
                    // idx stops on the last slice rather than wrapping.
                    if (idx_q == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = res_q;
    assign cout      = carry_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Randomized and directed bench for wide_add_seq at 512/32, plus a 64/8 instance.
// A cycle-level model (pending flag, accept cycle, expected {cout,sum}) is checked every negedge.
module tb_wide_add_seq;

    localparam int W  = 512;
    localparam int S  = 32;
    localparam int N  = W / S;
    localparam int W2 = 64;
    localparam int S2 = 8;
    localparam int N2 = W2 / S2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          op_sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          cout;

    logic          s_in_valid = 1'b0;
    logic          s_in_ready;
    logic [W2-1:0] s_a = '0;
    logic [W2-1:0] s_b = '0;
    logic          s_cin = 1'b0;
    logic          s_op_sub = 1'b0;
    logic          s_out_valid;
    logic          s_out_ready = 1'b1;
    logic [W2-1:0] s_sum;
    logic          s_cout;

    wide_add_seq #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    wide_add_seq #(.WIDTH(W2), .SLICE(S2)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .op_sub(s_op_sub),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .cout(s_cout)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out, got no handshake expected one (cycle %0d)", name, cyc);
    endtask

    function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic [W2:0] ref_op2(input logic [W2-1:0] x, input logic [W2-1:0] y,
                                            input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + (W2+1)'(1);
        return {1'b0, x} + {1'b0, y} + {{W2{1'b0}}, c};
    endfunction

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] v;
        int sel;
        sel = $urandom_range(0, 7);
        v = '0;
        if (sel == 1) v = '1;
        else if (sel == 2) v[31:0] = $urandom;
        else if (sel >= 3) for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Model state: one operation in flight at most.
    bit           pend = 0;
    int           acc_cyc = 0;
    logic [W:0]   exp_res = '0;
    int           n_done = 0;
    logic [W-1:0] last_sum = '0;
    logic         last_cout = 1'b0;
    bit           b2b = 0;
    bit           prev_b2b = 0;
    int           prev_acc = 0;

    bit           s_pend = 0;
    int           s_acc_cyc = 0;
    logic [W2:0]  s_exp_res = '0;
    int           s_n_done = 0;

    always @(negedge clk) begin
        bit acc, done, s_acc, s_done;
        if (!rst_n) begin
            pend   = 0;
            s_pend = 0;
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_sum_cout", {cout, sum}, 0);
            check("rst_small", {s_in_ready, s_out_valid, s_cout, s_sum}, {1'b1, 1'b0, 1'b0, {W2{1'b0}}});
        end else begin
            check("in_ready", in_ready, !pend);
            check("out_valid", out_valid, pend && (cyc >= acc_cyc + N + 1));
            if (pend && out_valid) check("result", {cout, sum}, exp_res);
            acc  = !pend && in_valid;
            done = pend && out_valid && out_ready;
            if (done) begin
                pend      = 0;
                last_sum  = sum;
                last_cout = cout;
                n_done++;
            end
            if (acc) begin
                if (b2b && prev_b2b) check("b2b_spacing", cyc - prev_acc, N + 2);
                prev_acc = cyc;
                prev_b2b = b2b;
                pend     = 1;
                acc_cyc  = cyc;
                exp_res  = ref_op(a, b, cin, op_sub);
            end

            check("s_in_ready", s_in_ready, !s_pend);
            check("s_out_valid", s_out_valid, s_pend && (cyc >= s_acc_cyc + N2 + 1));
            if (s_pend && s_out_valid) check("s_result", {s_cout, s_sum}, s_exp_res);
            s_acc  = !s_pend && s_in_valid;
            s_done = s_pend && s_out_valid && s_out_ready;
            if (s_done) begin
                s_pend = 0;
                s_n_done++;
            end
            if (s_acc) begin
                s_pend    = 1;
                s_acc_cyc = cyc;
                s_exp_res = ref_op2(s_a, s_b, s_cin, s_op_sub);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
        bit got;
        a = x; b = y; cin = c; op_sub = s; in_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        step();
        in_valid = 1'b0;
        if (!got) timeout("accept");
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 400 && n_done < target; i++) step();
        if (n_done < target) timeout("completion");
    endtask

    // Small instance runs its own random traffic throughout.
    initial begin
        forever begin
            step();
            s_in_valid  = ($urandom_range(0, 2) != 0);
            s_out_ready = ($urandom_range(0, 3) != 0);
            s_a      = ($urandom_range(0, 5) == 0) ? '1 : {$urandom, $urandom};
            s_b      = {$urandom, $urandom};
            s_cin    = 1'($urandom);
            s_op_sub = 1'($urandom);
        end
    end

    initial begin
        logic [W:0] e;
        int target;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Full carry ripple through every slice.
        do_op('1, '0, 1'b1, 1'b0);
        wait_done(n_done + 1);
        e = '0; e[W] = 1'b1;
        check("ripple_all_ones", {last_cout, last_sum}, e);

        // 5 - 7 borrows: all ones except bit 0, no carry out.
        do_op(W'(5), W'(7), 1'b0, 1'b1);
        wait_done(n_done + 1);
        e = '1; e[0] = 1'b0; e[W] = 1'b0;
        check("sub_borrow", {last_cout, last_sum}, e);

        // 7 - 5 = 2, carry out 1 means no borrow; cin ignored for subtract.
        do_op(W'(7), W'(5), 1'b1, 1'b1);
        wait_done(n_done + 1);
        e = '0; e[1] = 1'b1; e[W] = 1'b1;
        check("sub_no_borrow", {last_cout, last_sum}, e);

        // Stall in DONE with a new request held; it must wait for the handshake.
        out_ready = 1'b0;
        a = rnd_w(); b = rnd_w(); cin = 1'b1; op_sub = 1'b0; in_valid = 1'b1;
        repeat (N + 22) step();
        check("stall_out_valid", out_valid, 1);
        target = n_done + 2;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && n_done < target; i++) step();
        in_valid = 1'b0;
        if (n_done < target) timeout("stall_release");
        step();

        // Reset while slice 7 is being processed discards the operation.
        do_op(rnd_w(), rnd_w(), 1'b1, 1'b0);
        repeat (7) step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        do_op(W'(3), W'(4), 1'b0, 1'b0);
        wait_done(n_done + 1);
        e = '0; e[2:0] = 3'd7;
        check("post_reset_op", {last_cout, last_sum}, e);

        // Back-to-back with operands scrambled every cycle.
        b2b = 1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        target = n_done + 500;
        for (int i = 0; i < 500 * (N + 2) + 200 && n_done < target; i++) begin
            a = rnd_w(); b = rnd_w(); cin = 1'($urandom); op_sub = 1'($urandom);
            step();
        end
        if (n_done < target) timeout("b2b_phase");
        in_valid = 1'b0;
        b2b = 0;
        step();

        // Random valid and ready.
        target = n_done + 500;
        for (int i = 0; i < 40000 && n_done < target; i++) begin
            a = rnd_w(); b = rnd_w(); cin = 1'($urandom); op_sub = 1'($urandom);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        if (n_done < target) timeout("random_phase");
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (N + 4) step();

        check("small_ops_seen", (s_n_done >= 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
